// File: rtl/instr_fetch_pkg.sv
// Shared MIPS fetch-stage types and opcode constants.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_J     = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;
    localparam logic [OP_W-1:0] FUNCT_JR = 6'd8;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } fetch_state_t;

    // One fetched instruction together with its fall-through address.
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc4;
    } fetch_word_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between fetch (master) and memory (slave).
interface instr_fetch_if;
    import mips_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/instr_fetch_skid.sv
// One-entry skid buffer holding a word returned while decode was stalled.
module fetch_skid
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  fetch_word_t data_i,
    output fetch_word_t data_o,
    output logic        full_o
);

    fetch_word_t data_q;
    logic        full_q;

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (clear_i) begin
                full_q <= 1'b0;
            end else if (load_i) begin
                full_q <= 1'b1;
            end
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: PC, imem req/ack, IF/ID register, skid and redirect flush.
// Define INSTR_FETCH_JUMP_EN to redirect locally on a delivered j instruction.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] if_pc4,
    output logic [OP_W-1:0]   opcode,
    output logic [OP_W-1:0]   funct
);

`ifdef INSTR_FETCH_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc4_q, pc4_d;
    logic              jmp_q, jmp_d;

    logic              adv, ack, outstanding, wr;
    logic [ADDR_W-1:0] pc_inc;
    logic              skid_load, skid_clear, skid_full;
    fetch_word_t       skid_in, skid_out;

    // Acks are only meaningful while a request is actually on the bus.
    assign adv         = !valid_q || !stall;
    assign ack         = imem.imem_ack && req_q;
    assign outstanding = req_q && !imem.imem_ack;
    assign pc_inc      = pc_q + ADDR_W'(4);
    assign skid_in     = '{instr: imem.imem_rdata, pc4: WORD_W'(pc_inc)};

    fetch_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (skid_in),
        .data_o  (skid_out),
        .full_o  (skid_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
            jmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            jmp_q   <= jmp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        wr         = 1'b0;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            state_d    = outstanding ? DROP : FETCH;
        end else if (JUMP_EN && jmp_q) begin
            // The j word stays in the output; only the fall-through fetch is discarded.
            pc_d       = ADDR_W'({pc4_q[31:28], instr_q[25:0], 2'b00});
            skid_clear = 1'b1;
            state_d    = outstanding ? DROP : FETCH;
            if (adv) valid_d = 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_inc;
                        if (adv) begin
                            valid_d = 1'b1;
                            instr_d = imem.imem_rdata;
                            pc4_d   = WORD_W'(pc_inc);
                            wr      = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end else if (adv) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_d    = skid_full;
                        instr_d    = skid_out.instr;
                        pc4_d      = skid_out.pc4;
                        skid_clear = 1'b1;
                        wr         = 1'b1;
                        state_d    = FETCH;
                    end
                end
                DROP: begin
                    if (ack) state_d = FETCH;
                    if (adv) valid_d = 1'b0;
                end
                default: state_d = FETCH;
            endcase
        end

        req_d = (state_d != HOLD);
        jmp_d = JUMP_EN && wr && (instr_d[31:26] == OP_J);
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = WORD_W'(pc_q);
    assign if_valid       = valid_q;
    assign if_instr       = instr_q;
    assign if_pc4         = pc4_q;
    assign opcode         = instr_q[31:26];
    assign funct          = instr_q[5:0];

endmodule
